mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that sits directly upstream of the 4-to-1 data mux and drives its 2-bit select. It accepts per-channel requests from four sources and grants one channel at a time with a fair rotating priority. It holds the select stable under downstream backpressure and returns a one-cycle grant acknowledge to the winning source on each transfer. A watchdog flags a downstream stall that lasts too long.

## Interface
- `STALL_MAX`, default 15: consecutive backpressure cycles in BUSY before `stall_err` sets. Legal range 1..255.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  4  per-channel request; bit i = source i has a word on mux input i.
- `out_ready`  in  1  downstream accepts the muxed word this cycle.
- `sel`  out  2  select to the 4-to-1 mux; registered.
- `out_valid`  out  1  muxed word is valid; registered.
- `gnt`  out  4  one-hot transfer acknowledge to the source; combinational.
- `stall_err`  out  1  sticky watchdog flag; registered.

## Operation
- State machine has two states, IDLE and BUSY. There is an internal 2-bit `ptr` holding the last granted channel and an 8-bit stall counter `scnt`.
- Arbitration: the search starts at `ptr+1` mod 4 and walks upward with wrap-around. The first index with `req` set wins.
- IDLE:
  - If `req != 0`, the winner is registered: `sel` <= winner, `out_valid` <= 1, go to BUSY.
  - Otherwise stay in IDLE with `out_valid` = 0 and `sel` unchanged.
- BUSY, transfer case (`out_ready` = 1):
  - `gnt[sel]` = 1 this cycle, and `ptr` <= `sel`.
  - Re-arbitrate with `req[sel]` masked.
  - If another channel requests, load it into `sel`, keep `out_valid` = 1, stay in BUSY.
  - Otherwise `out_valid` <= 0 and go to IDLE.
  - A lone streaming source therefore gets one idle cycle between words. This is intended.
- BUSY, backpressure case (`out_ready` = 0, `req[sel]` = 1):
  - Hold `sel`, `out_valid`, and `ptr`.
  - `scnt` increments and saturates at 255.
- BUSY, abort case (`req[sel]` = 0 while `out_ready` = 0):
  - Sources must hold `req` until they see `gnt`; this case is a source violation.
  - `out_valid` <= 0, go to IDLE, no `gnt`, `ptr` unchanged.
- Stall counter:
  - `scnt` clears on any transfer, on abort, and in IDLE.
  - When `scnt` reaches `STALL_MAX`, `stall_err` <= 1. It stays set until reset and arbitration continues normally.
- `gnt` = one-hot(`sel`) when `out_valid & out_ready`, else 0. It never has more than one bit set.

## Timing
- Reset values (async assert, synchronous effect on deassert):
  - state = IDLE, `sel` = 2'b00, `out_valid` = 0, `gnt` = 0, `stall_err` = 0.
  - `ptr` = 2'b11, so channel 0 has first priority.
  - `scnt` = 0.
- Latency from `req` rising in IDLE to `out_valid` high is 1 cycle.
- Back-to-back transfers between different channels need no bubble: `out_valid` stays high and `sel` changes on the edge after the transfer.
- `sel` never changes while `out_valid` = 1 and `out_ready` = 0.
- `gnt` is combinational from registered `sel`/`out_valid` and the input `out_ready`. It is valid in the same cycle as the transfer.
- Reset asserted mid-BUSY: outputs go to their reset values immediately, with no clock needed. Any pending transfer is lost and no `gnt` is issued.
- Simultaneous requests from all four channels with `out_ready` held at 1 give the grant order 0,1,2,3,0,...

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'b1111 -> `sel` = 00, `out_valid` = 0, `gnt` = 0, `stall_err` = 0. Release -> `out_valid` = 1 with `sel` = 00 one cycle later.
- Single request: `req` = 4'b0100, `out_ready` = 1 -> `sel` = 10, `gnt` = 4'b0100 for one cycle, then IDLE for one cycle, then re-grant of channel 2.
- Round robin: `req` = 4'b1111, `out_ready` = 1 for 5 transfers -> `sel` sequence 00,01,10,11,00 and `gnt` = 0001,0010,0100,1000,0001 with no gaps in `out_valid`.
- Backpressure and watchdog (`STALL_MAX` = 3): grant channel 1, hold `out_ready` = 0 for 5 cycles -> `sel` = 01 stable and `stall_err` set after 3 stalled cycles. Then `out_ready` = 1 -> `gnt` = 0010, and `stall_err` stays 1.
- Abort: grant channel 3, drop `req[3]` while `out_ready` = 0 -> `out_valid` = 0 next cycle, `gnt` never asserts, and the next grant with `req` = 4'b1001 is channel 0 (`ptr` still 11).
- Reset mid-operation: pull `rst_n` low during a stalled BUSY -> `out_valid`/`sel`/`stall_err` drop to reset values asynchronously. After release, `req` = 4'b1010 grants channel 1 first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4-to-1 data mux.
// Holds select under backpressure, acknowledges each transfer and watches for long stalls.
module mux_rr_arbiter #(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] gnt,
  output logic       stall_err
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic       r_out_valid;
  logic       r_stall_err;
  logic [7:0] r_scnt;

  logic [3:0] w_sel_oh;
  logic       w_xfer;
  logic [1:0] w_base;
  logic [3:0] w_cand;
  logic       w_found;
  logic [1:0] w_win;
  logic [7:0] w_scnt_inc;

  assign w_sel_oh   = 4'b0001 << r_sel;
  assign w_xfer     = r_out_valid & out_ready;
  // In BUSY the search is only used on a transfer, where ptr is about to become sel.
  assign w_base     = (r_state == StBusy) ? r_sel : r_ptr;
  assign w_cand     = (r_state == StBusy) ? (req & ~w_sel_oh) : req;
  assign w_scnt_inc = (r_scnt == 8'hFF) ? r_scnt : r_scnt + 8'd1;

  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_win   = w_base;
    idx     = w_base;
    for (int i = 1; i <= 4; i++) begin
      idx = w_base + 2'(i);
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= 2'b00;
      r_ptr       <= 2'b11;
      r_out_valid <= 1'b0;
      r_stall_err <= 1'b0;
      r_scnt      <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_scnt <= 8'd0;
          if (w_found) begin
            r_sel       <= w_win;
            r_out_valid <= 1'b1;
            r_state     <= StBusy;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        StBusy: begin
          if (out_ready) begin
            r_ptr  <= r_sel;
            r_scnt <= 8'd0;
            if (w_found) begin
              r_sel <= w_win;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= StIdle;
            end
          end else if (req[r_sel]) begin
            r_scnt <= w_scnt_inc;
            if (w_scnt_inc >= 8'(STALL_MAX)) r_stall_err <= 1'b1;
          end else begin
            // Source withdrew its request before being acknowledged: drop the word.
            r_out_valid <= 1'b0;
            r_scnt      <= 8'd0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign stall_err = r_stall_err;
  assign gnt       = w_xfer ? w_sel_oh : 4'b0000;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus queues expected grants,
// a negedge monitor pops and compares whenever gnt is asserted.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] gnt;
  logic       stall_err;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  mux_rr_arbiter #(.STALL_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .gnt       (gnt),
    .stall_err (stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every asserted gnt must match the next queued expectation.
  always @(negedge clk) begin
    if (gnt !== 4'b0000) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (gnt !== e || (4'b0001 << sel) !== e) begin
          n_err++;
          $display("FAIL gnt: got gnt=%b sel=%0d, expected gnt=%b", gnt, sel, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset values with all channels requesting
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_stall", 32'(stall_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_valid", 32'(out_valid), 32'd1);
    check("rel_sel", 32'(sel), 32'd0);
    req = 4'b0000;
    tick();
    check("rel_abort_valid", 32'(out_valid), 32'd0);

    // Single streaming source: grant, idle bubble, re-grant
    do_reset();
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    req = 4'b0100;
    out_ready = 1'b1;
    tick();
    check("single_sel", 32'(sel), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);
    tick();
    check("single_bubble", 32'(out_valid), 32'd0);
    tick();
    check("single_regrant", 32'(sel), 32'd2);
    req = 4'b0000;
    tick();
    check("single_idle", 32'(out_valid), 32'd0);

    // Round robin across all four channels
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_sel", 32'(sel), 32'(k % 4));
      check("rr_valid", 32'(out_valid), 32'd1);
    end
    req = 4'b0000;
    tick();
    check("rr_end_valid", 32'(out_valid), 32'd0);

    // Backpressure with watchdog at 3 stalled cycles
    do_reset();
    req = 4'b0010;
    tick();
    check("bp_sel", 32'(sel), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("bp_hold_sel", 32'(sel), 32'd1);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_stall", 32'(stall_err), (k >= 3) ? 32'd1 : 32'd0);
    end
    exp_q.push_back(4'b0010);
    out_ready = 1'b1;
    tick();
    req = 4'b0000;
    check("bp_after_valid", 32'(out_valid), 32'd0);
    check("bp_sticky", 32'(stall_err), 32'd1);
    tick();

    // Abort: channel 3 withdraws under backpressure, pointer unchanged
    do_reset();
    req = 4'b1000;
    tick();
    check("ab_sel", 32'(sel), 32'd3);
    req = 4'b0000;
    tick();
    check("ab_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(4'b0001);
    req = 4'b1001;
    out_ready = 1'b1;
    tick();
    check("ab_next_sel", 32'(sel), 32'd0);
    req = 4'b0000;
    tick();

    // Asynchronous reset during a stalled BUSY
    out_ready = 1'b0;
    req = 4'b0100;
    repeat (4) tick();
    check("mid_stall_pre", 32'(stall_err), 32'd1);
    check("mid_sel_pre", 32'(sel), 32'd2);
    #1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_sel", 32'(sel), 32'd0);
    check("mid_stall", 32'(stall_err), 32'd0);
    check("mid_gnt", 32'(gnt), 32'd0);
    req = 4'b1010;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    check("mid_first_sel", 32'(sel), 32'd1);
    req = 4'b0000;
    repeat (3) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
